// File: rtl/train_sched_ctrl.sv
// train_sched_ctrl
//   Training-schedule sequencer: issues N training and M validation sample
//   requests per epoch over a req/done handshake, sums validation error per
//   epoch, tracks the best epoch error (save strobe on improvement) and stops
//   on epoch limit, early-stop patience or abort.
//   Optional build macro: TRAIN_SCHED_LR_STEP_EN (adds lr_wait / lr_step).
module train_sched_ctrl #(
  parameter int BITS     = 16,
  parameter int ERR_BITS = 16,
  parameter int ACC_BITS = 24,
  parameter int PAT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BITS-1:0]     n_train,
  input  logic [BITS-1:0]     n_valid,
  input  logic [BITS-1:0]     n_epoch,
  input  logic [PAT_BITS-1:0] patience,
  input  logic                tr_done,
  input  logic                vl_done,
  input  logic [ERR_BITS-1:0] vl_err,
  output logic                tr_req,
  output logic                vl_req,
  output logic                save,
  output logic                busy,
  output logic                done,
  output logic [1:0]          stop_reason,
  output logic [BITS-1:0]     epoch_cnt,
  output logic [ACC_BITS-1:0] best_err
`ifdef TRAIN_SCHED_LR_STEP_EN
  ,
  input  logic [PAT_BITS-1:0] lr_wait,
  output logic [2:0]          lr_step
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TR_ISSUE = 3'd1;
  localparam logic [2:0] S_TR_WAIT  = 3'd2;
  localparam logic [2:0] S_VL_ISSUE = 3'd3;
  localparam logic [2:0] S_VL_WAIT  = 3'd4;
  localparam logic [2:0] S_EVAL     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [1:0] R_NONE  = 2'd0;
  localparam logic [1:0] R_EPOCH = 2'd1;
  localparam logic [1:0] R_EARLY = 2'd2;
  localparam logic [1:0] R_ABORT = 2'd3;

  logic [2:0]          state_q,   state_d;
  logic [BITS-1:0]     n_train_q, n_train_d;
  logic [BITS-1:0]     n_valid_q, n_valid_d;
  logic [BITS-1:0]     n_epoch_q, n_epoch_d;
  logic [PAT_BITS-1:0] pat_q,     pat_d;
  logic [BITS-1:0]     tr_cnt_q,  tr_cnt_d;
  logic [BITS-1:0]     vl_cnt_q,  vl_cnt_d;
  logic [BITS-1:0]     epoch_q,   epoch_d;
  logic [ACC_BITS-1:0] acc_q,     acc_d;
  logic [ACC_BITS-1:0] best_q,    best_d;
  logic [PAT_BITS-1:0] stall_q,   stall_d;
  logic [1:0]          reason_q,  reason_d;

  logic [ACC_BITS:0]   acc_sum;
  logic [ACC_BITS-1:0] acc_sat;
  logic [BITS-1:0]     tr_cnt_inc;
  logic [BITS-1:0]     vl_cnt_inc;
  logic [BITS-1:0]     epoch_inc;
  logic [PAT_BITS-1:0] stall_inc;
  logic [PAT_BITS-1:0] stall_new;
  logic                improve;

`ifdef TRAIN_SCHED_LR_STEP_EN
  logic [PAT_BITS-1:0] lr_wait_q, lr_wait_d;
  logic [2:0]          lr_step_q, lr_step_d;
  logic                lr_hit;
`endif

  // First phase of an epoch: empty sample sets are skipped entirely.
  function automatic logic [2:0] first_state(input logic [BITS-1:0] nt,
                                             input logic [BITS-1:0] nv);
    if (nt != '0)      return S_TR_ISSUE;
    else if (nv != '0) return S_VL_ISSUE;
    else               return S_EVAL;
  endfunction

  // Arithmetic shared by the FSM: saturating accumulate, counter increments.
  always_comb begin
    acc_sum    = {1'b0, acc_q} + {{(ACC_BITS + 1 - ERR_BITS){1'b0}}, vl_err};
    acc_sat    = acc_sum[ACC_BITS] ? '1 : acc_sum[ACC_BITS-1:0];
    tr_cnt_inc = tr_cnt_q + BITS'(1);
    vl_cnt_inc = vl_cnt_q + BITS'(1);
    epoch_inc  = epoch_q + BITS'(1);
    stall_inc  = (stall_q == '1) ? stall_q : stall_q + PAT_BITS'(1);
    improve    = (acc_q < best_q);
    stall_new  = improve ? '0 : stall_inc;
  end

`ifdef TRAIN_SCHED_LR_STEP_EN
  // LR step condition: new stall count is a nonzero multiple of lr_wait.
  always_comb begin
    lr_hit = 1'b0;
    if (lr_wait_q != '0 && stall_inc != '0) begin
      lr_hit = ((stall_inc % lr_wait_q) == '0);
    end
  end
`endif

  // Next-state and datapath update for the schedule FSM.
  always_comb begin
    state_d   = state_q;
    n_train_d = n_train_q;
    n_valid_d = n_valid_q;
    n_epoch_d = n_epoch_q;
    pat_d     = pat_q;
    tr_cnt_d  = tr_cnt_q;
    vl_cnt_d  = vl_cnt_q;
    epoch_d   = epoch_q;
    acc_d     = acc_q;
    best_d    = best_q;
    stall_d   = stall_q;
    reason_d  = reason_q;
`ifdef TRAIN_SCHED_LR_STEP_EN
    lr_wait_d = lr_wait_q;
    lr_step_d = lr_step_q;
`endif

    if (state_q == S_IDLE || state_q == S_DONE) begin
      if (start) begin
        n_train_d = n_train;
        n_valid_d = n_valid;
        n_epoch_d = n_epoch;
        pat_d     = patience;
        tr_cnt_d  = '0;
        vl_cnt_d  = '0;
        epoch_d   = '0;
        acc_d     = '0;
        best_d    = '1;
        stall_d   = '0;
        reason_d  = R_NONE;
`ifdef TRAIN_SCHED_LR_STEP_EN
        lr_wait_d = lr_wait;
        lr_step_d = '0;
`endif
        if (n_epoch == '0) begin
          state_d  = S_DONE;
          reason_d = R_EPOCH;
        end else begin
          state_d = first_state(n_train, n_valid);
        end
      end
    end else if (abort) begin
      // Abort beats any done strobe and the EVAL update in the same cycle.
      state_d  = S_DONE;
      reason_d = R_ABORT;
    end else begin
      case (state_q)
        S_TR_ISSUE: state_d = S_TR_WAIT;
        S_TR_WAIT: begin
          if (tr_done) begin
            tr_cnt_d = tr_cnt_inc;
            if (tr_cnt_inc == n_train_q) begin
              state_d = (n_valid_q != '0) ? S_VL_ISSUE : S_EVAL;
            end else begin
              state_d = S_TR_ISSUE;
            end
          end
        end
        S_VL_ISSUE: state_d = S_VL_WAIT;
        S_VL_WAIT: begin
          if (vl_done) begin
            vl_cnt_d = vl_cnt_inc;
            acc_d    = acc_sat;
            state_d  = (vl_cnt_inc == n_valid_q) ? S_EVAL : S_VL_ISSUE;
          end
        end
        S_EVAL: begin
          epoch_d = epoch_inc;
          stall_d = stall_new;
          if (improve) begin
            best_d = acc_q;
          end
`ifdef TRAIN_SCHED_LR_STEP_EN
          else if (lr_hit && lr_step_q != 3'd7) begin
            lr_step_d = lr_step_q + 3'd1;
          end
`endif
          if (epoch_inc == n_epoch_q) begin
            state_d  = S_DONE;
            reason_d = R_EPOCH;
          end else if (pat_q != '0 && stall_new >= pat_q) begin
            state_d  = S_DONE;
            reason_d = R_EARLY;
          end else begin
            acc_d    = '0;
            tr_cnt_d = '0;
            vl_cnt_d = '0;
            state_d  = first_state(n_train_q, n_valid_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_train_q <= '0;
      n_valid_q <= '0;
      n_epoch_q <= '0;
      pat_q     <= '0;
      tr_cnt_q  <= '0;
      vl_cnt_q  <= '0;
      epoch_q   <= '0;
      acc_q     <= '0;
      best_q    <= '1;
      stall_q   <= '0;
      reason_q  <= R_NONE;
    end else begin
      state_q   <= state_d;
      n_train_q <= n_train_d;
      n_valid_q <= n_valid_d;
      n_epoch_q <= n_epoch_d;
      pat_q     <= pat_d;
      tr_cnt_q  <= tr_cnt_d;
      vl_cnt_q  <= vl_cnt_d;
      epoch_q   <= epoch_d;
      acc_q     <= acc_d;
      best_q    <= best_d;
      stall_q   <= stall_d;
      reason_q  <= reason_d;
    end
  end

`ifdef TRAIN_SCHED_LR_STEP_EN
  // Learning-rate step registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_wait_q <= '0;
      lr_step_q <= '0;
    end else begin
      lr_wait_q <= lr_wait_d;
      lr_step_q <= lr_step_d;
    end
  end

  assign lr_step = lr_step_q;
`endif

  // Request/save pulses are decoded from state; abort suppresses them.
  assign tr_req      = (state_q == S_TR_ISSUE) && !abort;
  assign vl_req      = (state_q == S_VL_ISSUE) && !abort;
  assign save        = (state_q == S_EVAL) && !abort && improve;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign stop_reason = reason_q;
  assign epoch_cnt   = epoch_q;
  assign best_err    = best_q;

endmodule

// File: tb/tb_train_sched_ctrl.sv
// Self-checking bench for train_sched_ctrl: table vectors, hand-written
// corner sequences and randomized runs against an epoch-level model.
module tb_train_sched_ctrl;

  typedef struct packed {
    logic [15:0]       nt;
    logic [15:0]       nv;
    logic [15:0]       ne;
    logic [7:0]        pat;
    logic [7:0]        lrw;
    logic [3:0]        dly;   // done latency after req; 0 = random 1..3
    logic [7:0][15:0]  errs;  // per-sample error used in epoch k (k>=7 uses 7)
  } cfg_t;

  typedef struct packed {
    logic [1:0]  reason;
    logic [15:0] epochs;
    logic [23:0] best;
    logic [7:0]  mask;        // bit k: save seen in epoch k+1
    logic [15:0] trs;
    logic [15:0] vls;
    logic [2:0]  lr;
  } exp_t;

  typedef struct packed {
    cfg_t cfg;
    exp_t exp;
  } vec_t;

  logic        clk, rst_n, start, abort, tr_done, vl_done;
  logic [15:0] n_train, n_valid, n_epoch, vl_err;
  logic [7:0]  patience;
  logic        tr_req, vl_req, save, busy, done;
  logic [1:0]  stop_reason;
  logic [15:0] epoch_cnt;
  logic [23:0] best_err;
  logic        tr_req16, vl_req16, save16, busy16, done16;
  logic [1:0]  stop_reason16;
  logic [15:0] epoch_cnt16;
  logic [15:0] best_err16;
`ifdef TRAIN_SCHED_LR_STEP_EN
  logic [7:0]  lr_wait;
  logic [2:0]  lr_step, lr_step16;
`endif

  int n_chk, n_err;
  int tr_tot, vl_tot, save_tot, save16_tot, vl16_tot, tr16_tot;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  train_sched_ctrl #(.BITS(16), .ERR_BITS(16), .ACC_BITS(24), .PAT_BITS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .n_train(n_train), .n_valid(n_valid), .n_epoch(n_epoch), .patience(patience),
    .tr_done(tr_done), .vl_done(vl_done), .vl_err(vl_err),
    .tr_req(tr_req), .vl_req(vl_req), .save(save), .busy(busy), .done(done),
    .stop_reason(stop_reason), .epoch_cnt(epoch_cnt), .best_err(best_err)
`ifdef TRAIN_SCHED_LR_STEP_EN
    , .lr_wait(lr_wait), .lr_step(lr_step)
`endif
  );

  train_sched_ctrl #(.BITS(16), .ERR_BITS(16), .ACC_BITS(16), .PAT_BITS(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .n_train(n_train), .n_valid(n_valid), .n_epoch(n_epoch), .patience(patience),
    .tr_done(tr_done), .vl_done(vl_done), .vl_err(vl_err),
    .tr_req(tr_req16), .vl_req(vl_req16), .save(save16), .busy(busy16), .done(done16),
    .stop_reason(stop_reason16), .epoch_cnt(epoch_cnt16), .best_err(best_err16)
`ifdef TRAIN_SCHED_LR_STEP_EN
    , .lr_wait(lr_wait), .lr_step(lr_step16)
`endif
  );

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (tr_req)   tr_tot++;
    if (vl_req)   vl_tot++;
    if (save)     save_tot++;
    if (save16)   save16_tot++;
    if (vl_req16) vl16_tot++;
    if (tr_req16) tr16_tot++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; tr_done = 1'b0; vl_done = 1'b0;
  endtask

  // which: 0 tr_req, 1 vl_req, 2 done
  task automatic wait_sig(input int which, input int maxc, input string nm);
    int  k;
    bit  hit;
    k = 0; hit = 1'b0;
    while (!hit && k < maxc) begin
      step();
      hit = (which == 0) ? tr_req : (which == 1) ? vl_req : done;
      k++;
    end
    n_chk++;
    if (!hit) begin
      n_err++;
      $display("FAIL %s: not seen within %0d cycles", nm, maxc);
    end
  endtask

  // Epoch-level reference: walks the epochs using the schedule rules directly.
  function automatic exp_t model(cfg_t c);
    exp_t   e;
    longint best, sum;
    int     stall, lr, ep, ei;
    e = '0; best = 64'hFFFFFF; stall = 0; lr = 0; ep = 0;
    e.reason = 2'd1;
    for (int k = 0; k < int'(c.ne); k++) begin
      ei  = (k > 7) ? 7 : k;
      sum = longint'(c.nv) * longint'(c.errs[ei]);
      if (sum > 64'hFFFFFF) sum = 64'hFFFFFF;
      ep = k + 1;
      if (sum < best) begin
        best = sum; stall = 0;
        if (k < 8) e.mask[k] = 1'b1;
      end else begin
        if (stall < 255) stall++;
        if (c.lrw != 0 && (stall % int'(c.lrw)) == 0 && lr < 7) lr++;
      end
      if (ep == int'(c.ne)) begin e.reason = 2'd1; break; end
      if (c.pat != 0 && stall >= int'(c.pat)) begin e.reason = 2'd2; break; end
    end
    e.epochs = 16'(ep);
    e.best   = 24'(best);
    e.trs    = 16'(int'(c.nt) * ep);
    e.vls    = 16'(int'(c.nv) * ep);
    e.lr     = 3'(lr);
    return e;
  endfunction

  // Starts a run and answers every request until done (bounded).
  task automatic do_run(input cfg_t c, output exp_t r);
    int trp, vlp, vl_seen, trs, vls, ei, k, d;
    bit fin;
    logic [15:0] nerr;
    n_train = c.nt; n_valid = c.nv; n_epoch = c.ne; patience = c.pat;
`ifdef TRAIN_SCHED_LR_STEP_EN
    lr_wait = c.lrw;
`endif
    r = '0; trp = 0; vlp = 0; vl_seen = 0; trs = 0; vls = 0; k = 0; fin = 1'b0; nerr = '0;
    start = 1'b1;
    while (!fin && k < 5000) begin
      @(posedge clk); #1;
      k++;
      start = 1'b0; tr_done = 1'b0; vl_done = 1'b0;
      if (trp > 0) begin trp--; if (trp == 0) tr_done = 1'b1; end
      if (vlp > 0) begin
        vlp--;
        if (vlp == 0) begin vl_done = 1'b1; vl_err = nerr; end
      end
      d = (c.dly != 0) ? int'(c.dly) : int'($urandom_range(1, 3));
      if (tr_req) begin trs++; trp = d; end
      if (vl_req) begin
        ei = (c.nv != 0) ? vl_seen / int'(c.nv) : 0;
        if (ei > 7) ei = 7;
        nerr = c.errs[ei];
        vl_seen++; vls++; vlp = d;
      end
      if (save && epoch_cnt < 16'd8) r.mask[epoch_cnt[2:0]] = 1'b1;
      if (done) fin = 1'b1;
    end
    tr_done = 1'b0; vl_done = 1'b0;
    n_chk++;
    if (!fin) begin
      n_err++;
      $display("FAIL run_done: done not reached within 5000 cycles");
    end
    r.reason = stop_reason;
    r.epochs = epoch_cnt;
    r.best   = best_err;
    r.trs    = 16'(trs);
    r.vls    = 16'(vls);
`ifdef TRAIN_SCHED_LR_STEP_EN
    r.lr     = lr_step;
`endif
  endtask

  task automatic run_check(input string nm, input cfg_t c, input exp_t e);
    exp_t r;
    do_run(c, r);
    chk({nm, " reason"}, 64'(r.reason), 64'(e.reason));
    chk({nm, " epochs"}, 64'(r.epochs), 64'(e.epochs));
    chk({nm, " best"},   64'(r.best),   64'(e.best));
    chk({nm, " saves"},  64'(r.mask),   64'(e.mask));
    chk({nm, " tr_req"}, 64'(r.trs),    64'(e.trs));
    chk({nm, " vl_req"}, 64'(r.vls),    64'(e.vls));
    chk({nm, " busy"},   64'(busy),     64'(0));
`ifdef TRAIN_SCHED_LR_STEP_EN
    chk({nm, " lr_step"}, 64'(r.lr),    64'(e.lr));
`endif
  endtask

  function automatic vec_t mk(input int nt, nv, ne, pat, dly, e0, e1, e2, e3,
                              input int rsn, ep, best, mask, trs, vls);
    vec_t v;
    v = '0;
    v.cfg.nt = 16'(nt); v.cfg.nv = 16'(nv); v.cfg.ne = 16'(ne);
    v.cfg.pat = 8'(pat); v.cfg.dly = 4'(dly);
    v.cfg.errs[0] = 16'(e0); v.cfg.errs[1] = 16'(e1); v.cfg.errs[2] = 16'(e2);
    for (int j = 3; j < 8; j++) v.cfg.errs[j] = 16'(e3);
    v.exp.reason = 2'(rsn); v.exp.epochs = 16'(ep); v.exp.best = 24'(best);
    v.exp.mask = 8'(mask); v.exp.trs = 16'(trs); v.exp.vls = 16'(vls);
    return v;
  endfunction

  vec_t vecs [7];

  initial begin
    int   s0, s16, v16, t16, t0;
    cfg_t c;
    exp_t e;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tr_done = 1'b0; vl_done = 1'b0;
    vl_err = '0; n_train = '0; n_valid = '0; n_epoch = '0; patience = '0;
`ifdef TRAIN_SCHED_LR_STEP_EN
    lr_wait = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst reason", 64'(stop_reason), 64'(0));
    chk("rst epoch", 64'(epoch_cnt), 64'(0));
    chk("rst best", 64'(best_err), 64'hFFFFFF);
    chk("rst pulses", 64'({tr_req, vl_req, save}), 64'(0));

    //       nt nv ne  pat dly e0  e1  e2  e3  rsn ep best       mask trs vls
    vecs[0] = mk(3, 2, 2,  0,  1, 5,  5,  5,  5,  1,  2, 10,        1,  6,  4);
    vecs[1] = mk(1, 1, 10, 2,  2, 20, 15, 18, 19, 2,  4, 15,        3,  4,  4);
    vecs[2] = mk(0, 0, 3,  0,  1, 0,  0,  0,  0,  1,  3, 0,         1,  0,  0);
    vecs[3] = mk(2, 0, 2,  1,  1, 0,  0,  0,  0,  1,  2, 0,         1,  4,  0);
    vecs[4] = mk(1, 1, 3,  1,  3, 9,  8,  7,  7,  1,  3, 7,         7,  3,  3);
    vecs[5] = mk(0, 2, 5,  3,  1, 6,  6,  6,  6,  2,  4, 12,        1,  0,  8);
    vecs[6] = mk(2, 1, 0,  0,  1, 1,  1,  1,  1,  1,  0, 'hFFFFFF,  0,  0,  0);
    for (int i = 0; i < 7; i++) run_check($sformatf("vec%0d", i), vecs[i].cfg, vecs[i].exp);

    // Saturation: 3 x FFFF overflows a 16-bit accumulator; the clamped sum
    // ties the all-ones initial best, so the narrow instance never saves.
    c = '0; c.nv = 16'd3; c.ne = 16'd1; c.dly = 4'd1;
    for (int j = 0; j < 8; j++) c.errs[j] = 16'hFFFF;
    s16 = save16_tot; v16 = vl16_tot; t16 = tr16_tot;
    run_check("sat24", c, model(c));
    chk("sat16 best", 64'(best_err16), 64'hFFFF);
    chk("sat16 saves", 64'(save16_tot - s16), 64'(0));
    chk("sat16 vl_req", 64'(vl16_tot - v16), 64'(3));
    chk("sat16 tr_req", 64'(tr16_tot - t16), 64'(0));
    chk("sat16 state", 64'({done16, busy16, stop_reason16}), 64'({1'b1, 1'b0, 2'd1}));
    chk("sat16 epoch", 64'(epoch_cnt16), 64'(1));

    // Abort on the same cycle as vl_done in epoch 2; start while busy ignored.
    n_train = 16'd1; n_valid = 16'd2; n_epoch = 16'd5; patience = 8'd0;
`ifdef TRAIN_SCHED_LR_STEP_EN
    lr_wait = 8'd0;
`endif
    s0 = save_tot;
    start = 1'b1;
    wait_sig(0, 10, "ab tr_req1");
    start = 1'b1;
    step();
    chk("ab busy", 64'(busy), 64'(1));
    tr_done = 1'b1;
    wait_sig(1, 10, "ab vl_req1");
    step(); vl_err = 16'd4; vl_done = 1'b1;
    wait_sig(1, 10, "ab vl_req2");
    step(); vl_err = 16'd4; vl_done = 1'b1;
    wait_sig(0, 10, "ab tr_req2");
    chk("ab epoch1", 64'(epoch_cnt), 64'(1));
    chk("ab best1", 64'(best_err), 64'(8));
    chk("ab save1", 64'(save_tot - s0), 64'(1));
    step(); tr_done = 1'b1;
    wait_sig(1, 10, "ab vl_req3");
    step(); vl_err = 16'd4; vl_done = 1'b1;
    wait_sig(1, 10, "ab vl_req4");
    step(); vl_err = 16'd100; vl_done = 1'b1; abort = 1'b1;
    step();
    chk("ab done", 64'({done, busy}), 64'({1'b1, 1'b0}));
    chk("ab reason", 64'(stop_reason), 64'(3));
    chk("ab epoch", 64'(epoch_cnt), 64'(1));
    chk("ab best", 64'(best_err), 64'(8));
    chk("ab saves", 64'(save_tot - s0), 64'(1));
    // Restart from DONE clears the run status.
    start = 1'b1;
    step();
    chk("rs epoch", 64'(epoch_cnt), 64'(0));
    chk("rs flags", 64'({done, busy, stop_reason}), 64'({1'b0, 1'b1, 2'd0}));
    chk("rs best", 64'(best_err), 64'hFFFFFF);
    abort = 1'b1;
    step();
    chk("rs abort", 64'({done, stop_reason}), 64'({1'b1, 2'd3}));

    // n_epoch == 0: done one cycle after start, no requests.
    n_epoch = 16'd0; n_train = 16'd2; t0 = tr_tot;
    start = 1'b1;
    step();
    chk("ne0 done", 64'({done, busy, stop_reason}), 64'({1'b1, 1'b0, 2'd1}));
    step();
    chk("ne0 tr_req", 64'(tr_tot - t0), 64'(0));

    // Randomized runs against the epoch-level model.
    for (int i = 0; i < 40; i++) begin
      c = '0;
      c.nt  = 16'($urandom_range(0, 3));
      c.nv  = 16'($urandom_range(0, 3));
      c.ne  = 16'($urandom_range(0, 6));
      c.pat = 8'($urandom_range(0, 3));
      c.lrw = 8'($urandom_range(0, 2));
      for (int j = 0; j < 8; j++) c.errs[j] = 16'($urandom_range(0, 3));
      e = model(c);
      run_check($sformatf("rnd%0d", i), c, e);
    end

    // Asynchronous reset in TR_WAIT of epoch 2, then a stray tr_done.
    n_train = 16'd1; n_valid = 16'd0; n_epoch = 16'd3; patience = 8'd0;
`ifdef TRAIN_SCHED_LR_STEP_EN
    lr_wait = 8'd1;
`endif
    start = 1'b1;
    wait_sig(0, 10, "rr tr_req1");
    step(); tr_done = 1'b1;
    wait_sig(0, 10, "rr tr_req2");
    chk("rr epoch pre", 64'(epoch_cnt), 64'(1));
    step();
    rst_n = 1'b0;
    #2;
    chk("rr busy", 64'({busy, done}), 64'(0));
    chk("rr pulses", 64'({tr_req, vl_req, save}), 64'(0));
    chk("rr epoch", 64'(epoch_cnt), 64'(0));
    chk("rr best", 64'(best_err), 64'hFFFFFF);
    chk("rr reason", 64'(stop_reason), 64'(0));
`ifdef TRAIN_SCHED_LR_STEP_EN
    chk("rr lr_step", 64'(lr_step), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    t0 = tr_tot;
    step(); tr_done = 1'b1;
    step(); step();
    chk("rr stray busy", 64'({busy, done}), 64'(0));
    chk("rr stray tr_req", 64'(tr_tot - t0), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
